// File: rtl/spinner_multi.sv
// Multi-channel rotary-control synthesiser: one wrapping angle counter per player, driven by
// strobe-timed buttons or signed spinner deltas. Define SPINNER_DIR_EN to add the spin_dir output.
module spinner_multi #(
    parameter int CHANNELS    = 2,
    parameter int ANGLE_W     = 4,
    parameter int DIV         = 8,
    parameter int FAST_DIV    = 2,
    parameter int MOUSE_SHIFT = 2,
    parameter int ACC_W       = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        strobe,
    input  logic [CHANNELS-1:0]         use_spinner,
    input  logic [CHANNELS-1:0]         plus,
    input  logic [CHANNELS-1:0]         minus,
    input  logic [CHANNELS-1:0]         fast,
    input  logic                        delta_valid,
    input  logic [1:0]                  delta_ch,
    input  logic [8:0]                  delta,
    output logic [CHANNELS*ANGLE_W-1:0] spin_angle
`ifdef SPINNER_DIR_EN
    ,
    output logic [CHANNELS-1:0]         spin_dir
`endif
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LIM_SLOW = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] LIM_FAST = CNT_W'(FAST_DIV - 1);
    // Accumulator sums are formed one bit wider so saturation can be detected before truncation.
    localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W+1)'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SUM_MIN = -SUM_MAX - 1;

    logic strobe_d_reg;
    logic tick;

    assign tick = strobe & ~strobe_d_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) strobe_d_reg <= 1'b0;
        else       strobe_d_reg <= strobe;
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [ANGLE_W-1:0]      angle_reg, angle_next;
            logic [CNT_W-1:0]        cnt_reg, cnt_next;
            logic signed [ACC_W-1:0] acc_reg, acc_next;
            logic                    mode_reg;
            logic signed [ACC_W-1:0] step;
            logic signed [ACC_W-1:0] rem;
            logic signed [ACC_W:0]   sum;
            logic                    hit;
`ifdef SPINNER_DIR_EN
            logic dir_reg, dir_next;
`endif

            always_comb begin
                angle_next = angle_reg;
                cnt_next   = cnt_reg;
                acc_next   = acc_reg;
`ifdef SPINNER_DIR_EN
                dir_next   = dir_reg;
`endif
                step = acc_reg >>> MOUSE_SHIFT;
                rem  = acc_reg - (step <<< MOUSE_SHIFT);
                sum  = {acc_reg[ACC_W-1], acc_reg};
                hit  = delta_valid && (delta_ch == 2'(gi));

                if (use_spinner[gi] != mode_reg) begin
                    // Mode change: drop any partial progress, keep the angle.
                    cnt_next = '0;
                    acc_next = '0;
                end else if (!mode_reg) begin
                    if (plus[gi] ^ minus[gi]) begin
                        if (tick) begin
                            if (cnt_reg >= (fast[gi] ? LIM_FAST : LIM_SLOW)) begin
                                cnt_next   = '0;
                                angle_next = plus[gi] ? angle_reg + ANGLE_W'(1)
                                                      : angle_reg - ANGLE_W'(1);
`ifdef SPINNER_DIR_EN
                                dir_next   = plus[gi];
`endif
                            end else begin
                                cnt_next = cnt_reg + CNT_W'(1);
                            end
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end else begin
                    if (tick) begin
                        angle_next = angle_reg + step[ANGLE_W-1:0];
                        sum        = {rem[ACC_W-1], rem};
`ifdef SPINNER_DIR_EN
                        if (step != '0) dir_next = ~step[ACC_W-1];
`endif
                    end
                    // A delta arriving on a tick lands after the step is taken out.
                    if (hit) sum = sum + {{(ACC_W+1-9){delta[8]}}, delta};
                    if (sum > SUM_MAX)      acc_next = SUM_MAX[ACC_W-1:0];
                    else if (sum < SUM_MIN) acc_next = SUM_MIN[ACC_W-1:0];
                    else                    acc_next = sum[ACC_W-1:0];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    angle_reg <= '0;
                    cnt_reg   <= '0;
                    acc_reg   <= '0;
                    mode_reg  <= 1'b0;
`ifdef SPINNER_DIR_EN
                    dir_reg   <= 1'b0;
`endif
                end else begin
                    angle_reg <= angle_next;
                    cnt_reg   <= cnt_next;
                    acc_reg   <= acc_next;
                    mode_reg  <= use_spinner[gi];
`ifdef SPINNER_DIR_EN
                    dir_reg   <= dir_next;
`endif
                end
            end

            assign spin_angle[gi*ANGLE_W +: ANGLE_W] = angle_reg;
`ifdef SPINNER_DIR_EN
            assign spin_dir[gi] = dir_reg;
`endif
        end
    endgenerate
endmodule
